// File: rtl/sseg_scan_capture.sv
// Multiplexed active-low seven-segment bus monitor: captures each digit, decodes it back
// to hex and publishes a frame after STABLE_SCANS identical scans. Define SSEG_DP_EN for decimal-point capture.
module sseg_scan_capture #(
  parameter int NDIG         = 4,
  parameter int SETTLE       = 2,
  parameter int STABLE_SCANS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        sseg,
`ifdef SSEG_DP_EN
  input  logic              dp,
  output logic [NDIG-1:0]   dp_out,
`endif
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   digit_err,
  output logic              frame_valid,
  output logic              glitch
);

  localparam logic [1:0] S_WAIT    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SCW = $clog2(STABLE_SCANS + 1);
  localparam logic [CW-1:0]  SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_SCANS);

  // Returns {err, value}; unknown patterns decode to value 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b1100000: decode = 5'h0B;
      7'b0110001: decode = 5'h0C;
      7'b1000010: decode = 5'h0D;
      7'b0110000: decode = 5'h0E;
      7'b0111000: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  logic [NDIG-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d, an_cap_q, an_cap_d;
  logic [6:0]        sseg_s1_q, sseg_s1_d, sseg_s2_q, sseg_s2_d;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [4*NDIG-1:0] work_val_q, work_val_d, prev_val_q, prev_val_d, digits_q, digits_d;
  logic [NDIG-1:0]   work_err_q, work_err_d, prev_err_q, prev_err_d, digit_err_q, digit_err_d;
  logic [SCW-1:0]    stable_q, stable_d;
  logic              frame_valid_q, frame_valid_d, glitch_q, glitch_d;
`ifdef SSEG_DP_EN
  logic              dp_s1_q, dp_s1_d, dp_s2_q, dp_s2_d;
  logic [NDIG-1:0]   work_dp_q, work_dp_d, prev_dp_q, prev_dp_d, dp_out_q, dp_out_d;
`endif

  logic [3:0] low_cnt;
  logic       one_hot, illegal, changed, capture, frame_same;
  logic [4:0] dec;

  always_comb begin
    an_s1_d       = an;
    an_s2_d       = an_s1_q;
    sseg_s1_d     = sseg;
    sseg_s2_d     = sseg_s1_q;
    an_prev_d     = an_s2_q;
    an_cap_d      = an_cap_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    mask_d        = mask_q;
    work_val_d    = work_val_q;
    work_err_d    = work_err_q;
    prev_val_d    = prev_val_q;
    prev_err_d    = prev_err_q;
    stable_d      = stable_q;
    digits_d      = digits_q;
    digit_err_d   = digit_err_q;
    frame_valid_d = 1'b0;
    capture       = 1'b0;
    dec           = decode(sseg_s2_q);
    frame_same    = (work_val_q == prev_val_q) && (work_err_q == prev_err_q);
`ifdef SSEG_DP_EN
    dp_s1_d    = dp;
    dp_s2_d    = dp_s1_q;
    work_dp_d  = work_dp_q;
    prev_dp_d  = prev_dp_q;
    dp_out_d   = dp_out_q;
    frame_same = frame_same && (work_dp_q == prev_dp_q);
`endif

    low_cnt = '0;
    for (int i = 0; i < NDIG; i++) low_cnt = low_cnt + {3'b000, ~an_s2_q[i]};
    one_hot = (low_cnt == 4'd1);
    illegal = (low_cnt > 4'd1);
    changed = (an_s2_q != an_cap_q);
    // Pulse only on entry into an illegal pattern, not for every cycle it persists.
    glitch_d = illegal && (an_s2_q != an_prev_q);

    case (state_q)
      S_WAIT: begin
        if (one_hot) begin
          state_d  = S_SETTLE;
          cnt_d    = SETTLE_LOAD;
          an_cap_d = an_s2_q;
        end
      end
      S_SETTLE: begin
        if (changed) begin
          state_d  = one_hot ? S_SETTLE : S_WAIT;
          cnt_d    = SETTLE_LOAD;
          an_cap_d = an_s2_q;
        end else if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CAPTURE: state_d = S_HOLD;
      default: begin
        // A change out of HOLD is evaluated as WAIT would in the same cycle.
        if (changed) begin
          state_d  = one_hot ? S_SETTLE : S_WAIT;
          cnt_d    = SETTLE_LOAD;
          an_cap_d = an_s2_q;
        end
      end
    endcase

    if (&mask_q) begin
      mask_d     = '0;
      stable_d   = !frame_same ? SCW'(1) : (stable_q < STABLE_MAX) ? stable_q + SCW'(1) : stable_q;
      prev_val_d = work_val_q;
      prev_err_d = work_err_q;
`ifdef SSEG_DP_EN
      prev_dp_d  = work_dp_q;
`endif
      if (stable_d == STABLE_MAX) begin
        digits_d      = work_val_q;
        digit_err_d   = work_err_q;
        frame_valid_d = 1'b1;
`ifdef SSEG_DP_EN
        dp_out_d      = work_dp_q;
`endif
      end
    end

    // The write happens as SETTLE hands over to CAPTURE, while the anode is still confirmed stable.
    if (capture) begin
      for (int i = 0; i < NDIG; i++) begin
        if (!an_cap_q[i]) begin
          work_val_d[4*i +: 4] = dec[3:0];
          work_err_d[i]        = dec[4];
          mask_d[i]            = 1'b1;
`ifdef SSEG_DP_EN
          work_dp_d[i]         = ~dp_s2_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_s1_q <= '0; an_s2_q <= '0; an_prev_q <= '0; an_cap_q <= '0;
      sseg_s1_q <= '0; sseg_s2_q <= '0;
      state_q <= S_WAIT; cnt_q <= '0; mask_q <= '0; stable_q <= '0;
      work_val_q <= '0; work_err_q <= '0; prev_val_q <= '0; prev_err_q <= '0;
      digits_q <= '0; digit_err_q <= '0; frame_valid_q <= 1'b0; glitch_q <= 1'b0;
`ifdef SSEG_DP_EN
      dp_s1_q <= 1'b0; dp_s2_q <= 1'b0; work_dp_q <= '0; prev_dp_q <= '0; dp_out_q <= '0;
`endif
    end else begin
      an_s1_q <= an_s1_d; an_s2_q <= an_s2_d; an_prev_q <= an_prev_d; an_cap_q <= an_cap_d;
      sseg_s1_q <= sseg_s1_d; sseg_s2_q <= sseg_s2_d;
      state_q <= state_d; cnt_q <= cnt_d; mask_q <= mask_d; stable_q <= stable_d;
      work_val_q <= work_val_d; work_err_q <= work_err_d;
      prev_val_q <= prev_val_d; prev_err_q <= prev_err_d;
      digits_q <= digits_d; digit_err_q <= digit_err_d;
      frame_valid_q <= frame_valid_d; glitch_q <= glitch_d;
`ifdef SSEG_DP_EN
      dp_s1_q <= dp_s1_d; dp_s2_q <= dp_s2_d;
      work_dp_q <= work_dp_d; prev_dp_q <= prev_dp_d; dp_out_q <= dp_out_d;
`endif
    end
  end

  assign digits      = digits_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign glitch      = glitch_q;
`ifdef SSEG_DP_EN
  assign dp_out      = dp_out_q;
`endif

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Bench for sseg_scan_capture (NDIG=4, SETTLE=2, STABLE_SCANS=2): scoreboard of expected
// published frames, checked whenever frame_valid pulses. SSEG_DP_EN adds the decimal-point scenario.
module tb_sseg_scan_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [6:0]  sseg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid, glitch;
`ifdef SSEG_DP_EN
  logic        dp = 1'b1;
  logic [3:0]  dp_out;
  int          dp_digit = -1;
`endif

  int checks = 0;
  int failures = 0;
  int fv_count = 0;
  int glitch_count = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_item;

  always #5 clk = ~clk;

  sseg_scan_capture #(.NDIG(4), .SETTLE(2), .STABLE_SCANS(2)) dut (
    .clk(clk),
    .rst(rst),
    .an(an),
    .sseg(sseg),
`ifdef SSEG_DP_EN
    .dp(dp),
    .dp_out(dp_out),
`endif
    .digits(digits),
    .digit_err(digit_err),
    .frame_valid(frame_valid),
    .glitch(glitch)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'b0000001;  4'h1: seg_of = 7'b1001111;
      4'h2: seg_of = 7'b0010010;  4'h3: seg_of = 7'b0000110;
      4'h4: seg_of = 7'b1001100;  4'h5: seg_of = 7'b0100100;
      4'h6: seg_of = 7'b0100000;  4'h7: seg_of = 7'b0001111;
      4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0000100;
      4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b1100000;
      4'hC: seg_of = 7'b0110001;  4'hD: seg_of = 7'b1000010;
      4'hE: seg_of = 7'b0110000;  default: seg_of = 7'b0111000;
    endcase
  endfunction

  // Scoreboard consumer: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (glitch) glitch_count++;
    if (frame_valid) begin
      fv_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_frame_valid: got pulse digits=%h err=%b, required no pulse", digits, digit_err);
      end else begin
        exp_item = exp_q.pop_front();
        checks++;
        if (digits !== exp_item[15:0]) begin
          failures++;
          $display("FAIL frame_digits: got %h, required %h", digits, exp_item[15:0]);
        end
        checks++;
        if (digit_err !== exp_item[19:16]) begin
          failures++;
          $display("FAIL frame_digit_err: got %b, required %b", digit_err, exp_item[19:16]);
        end
      end
    end
  end

  task automatic drive_digit(input logic [3:0] an_val, input logic [6:0] seg, input int dwell);
    an   = an_val;
    sseg = seg;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic scan_frame(input logic [15:0] vals, input int bad_dig, input int dwell,
                            input int short_dig, input int short_dwell);
    for (int d = 0; d < 4; d++) begin
`ifdef SSEG_DP_EN
      dp = (d == dp_digit) ? 1'b0 : 1'b1;
`endif
      drive_digit(~(4'b0001 << d), (d == bad_dig) ? 7'h7F : seg_of(vals[4*d +: 4]),
                  (d == short_dig) ? short_dwell : dwell);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; an = 4'hF; sseg = 7'h7F;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int fv0;
    repeat (3) @(negedge clk);
    checks++; if (digits !== 16'h0)     begin failures++; $display("FAIL reset_digits: got %h, required 0000", digits); end
    checks++; if (digit_err !== 4'h0)   begin failures++; $display("FAIL reset_digit_err: got %b, required 0000", digit_err); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid: got %b, required 0", frame_valid); end
    checks++; if (glitch !== 1'b0)      begin failures++; $display("FAIL reset_glitch: got %b, required 0", glitch); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    fv0 = fv_count;
    // One complete frame, then a partial one cut by a 2-cycle reset mid-capture.
    scan_frame(16'hFA43, -1, 8, -1, 0);
    drive_digit(4'b1110, seg_of(4'h3), 8);
    drive_digit(4'b1101, seg_of(4'h4), 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; an = 4'hF;
    checks++; if (digits !== 16'h0 || digit_err !== 4'h0)
      begin failures++; $display("FAIL midreset_outputs: got digits=%h err=%b, required 0000/0000", digits, digit_err); end
    repeat (4) @(negedge clk);
    scan_frame(16'hFA43, -1, 8, -1, 0);
    an = 4'hF; repeat (20) @(negedge clk);
    checks++; if (fv_count - fv0 !== 0)
      begin failures++; $display("FAIL midreset_first_frame: got %0d pulses, required 0", fv_count - fv0); end
    exp_q.push_back({4'b0000, 16'hFA43});
    scan_frame(16'hFA43, -1, 8, -1, 0);
    an = 4'hF; repeat (20) @(negedge clk);
    checks++; if (fv_count - fv0 !== 1)
      begin failures++; $display("FAIL midreset_publish: got %0d pulses, required 1", fv_count - fv0); end
    $display("test_reset done: pulses=%0d", fv_count - fv0);
  endtask

  task automatic test_basic();
    int fv0;
    apply_reset();
    fv0 = fv_count;
    scan_frame(16'hFA43, -1, 8, -1, 0);
    exp_q.push_back({4'b0000, 16'hFA43});
    scan_frame(16'hFA43, -1, 8, -1, 0);
    an = 4'hF; repeat (20) @(negedge clk);
    checks++; if (fv_count - fv0 !== 1)
      begin failures++; $display("FAIL basic_pulses: got %0d, required 1", fv_count - fv0); end
    checks++; if (digits !== 16'hFA43)
      begin failures++; $display("FAIL basic_digits_held: got %h, required FA43", digits); end
    checks++; if (exp_q.size() !== 0)
      begin failures++; $display("FAIL basic_drain: got %0d pending, required 0", exp_q.size()); end
    $display("test_basic done: digits=%h err=%b", digits, digit_err);
  endtask

  task automatic test_bad_digit();
    int fv0;
    apply_reset();
    fv0 = fv_count;
    scan_frame(16'hFA43, 1, 8, -1, 0);
    exp_q.push_back({4'b0010, 16'hFA03});
    scan_frame(16'hFA43, 1, 8, -1, 0);
    an = 4'hF; repeat (20) @(negedge clk);
    checks++; if (fv_count - fv0 !== 1 || exp_q.size() !== 0)
      begin failures++; $display("FAIL bad_digit_publish: got %0d pulses, required 1", fv_count - fv0); end
    $display("test_bad_digit done: digits=%h err=%b", digits, digit_err);
  endtask

  task automatic test_alternate();
    int fv0;
    apply_reset();
    fv0 = fv_count;
    for (int k = 0; k < 3; k++) begin
      scan_frame(16'h1234, -1, 8, -1, 0);
      scan_frame(16'h1235, -1, 8, -1, 0);
    end
    an = 4'hF; repeat (20) @(negedge clk);
    checks++; if (fv_count - fv0 !== 0)
      begin failures++; $display("FAIL alternate_pulses: got %0d, required 0", fv_count - fv0); end
    $display("test_alternate done: pulses=%0d", fv_count - fv0);
  endtask

  task automatic test_glitch();
    int fv0, g0;
    apply_reset();
    fv0 = fv_count;
    g0  = glitch_count;
    drive_digit(4'b1110, seg_of(4'h8), 8);
    drive_digit(4'b1101, seg_of(4'h7), 8);
    drive_digit(4'b1100, seg_of(4'h0), 3);
    drive_digit(4'b1011, seg_of(4'h6), 8);
    drive_digit(4'b0111, seg_of(4'h5), 8);
    an = 4'hF; repeat (10) @(negedge clk);
    checks++; if (glitch_count - g0 !== 1)
      begin failures++; $display("FAIL glitch_pulses: got %0d, required 1", glitch_count - g0); end
    exp_q.push_back({4'b0000, 16'h5678});
    scan_frame(16'h5678, -1, 8, -1, 0);
    an = 4'hF; repeat (20) @(negedge clk);
    checks++; if (fv_count - fv0 !== 1 || exp_q.size() !== 0)
      begin failures++; $display("FAIL glitch_publish: got %0d pulses, required 1", fv_count - fv0); end
    $display("test_glitch done: glitches=%0d pulses=%0d", glitch_count - g0, fv_count - fv0);
  endtask

  task automatic test_dwell();
    int fv0;
    apply_reset();
    fv0 = fv_count;
    scan_frame(16'hDCB9, -1, 8, 2, 2);
    scan_frame(16'hDCB9, -1, 8, 2, 2);
    an = 4'hF; repeat (20) @(negedge clk);
    checks++; if (fv_count - fv0 !== 0)
      begin failures++; $display("FAIL short_dwell_pulses: got %0d, required 0", fv_count - fv0); end
    scan_frame(16'hDCB9, -1, 4, -1, 0);
    exp_q.push_back({4'b0000, 16'hDCB9});
    scan_frame(16'hDCB9, -1, 4, -1, 0);
    an = 4'hF; repeat (20) @(negedge clk);
    checks++; if (fv_count - fv0 !== 1 || exp_q.size() !== 0)
      begin failures++; $display("FAIL dwell4_publish: got %0d pulses, required 1", fv_count - fv0); end
    $display("test_dwell done: pulses=%0d", fv_count - fv0);
  endtask

`ifdef SSEG_DP_EN
  task automatic test_dp();
    apply_reset();
    dp_digit = 2;
    scan_frame(16'h2468, -1, 8, -1, 0);
    exp_q.push_back({4'b0000, 16'h2468});
    scan_frame(16'h2468, -1, 8, -1, 0);
    dp_digit = -1; dp = 1'b1;
    an = 4'hF; repeat (20) @(negedge clk);
    checks++; if (dp_out !== 4'b0100)
      begin failures++; $display("FAIL dp_out: got %b, required 0100", dp_out); end
    $display("test_dp done: dp_out=%b", dp_out);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bad_digit();
    test_alternate();
    test_glitch();
    test_dwell();
`ifdef SSEG_DP_EN
    test_dp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
